// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, the program counter, program memory and execute.
// The sequencer side uses the master modport; the surrounding environment uses slave.
interface fetch_sequencer_if;
    logic [15:0]       CounterValue;
    logic [15:0]       LoadValue;
    logic              LoadEnable;
    logic signed [8:0] Offset;
    logic              OffsetEnable;
    logic [15:0]       InstrAddress;
    logic              InstrRead;
    logic              InstrReady;
    logic [15:0]       InstrData;
    logic [1:0]        Flags;
    logic [15:0]       InstrOut;
    logic [15:0]       InstrPC;
    logic              InstrValid;
    logic              InstrAccept;

    modport master (
        input  CounterValue, InstrReady, InstrData, Flags, InstrAccept,
        output LoadValue, LoadEnable, Offset, OffsetEnable,
               InstrAddress, InstrRead, InstrOut, InstrPC, InstrValid
    );

    modport slave (
        output CounterValue, InstrReady, InstrData, Flags, InstrAccept,
        input  LoadValue, LoadEnable, Offset, OffsetEnable,
               InstrAddress, InstrRead, InstrOut, InstrPC, InstrValid
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch and control-flow sequencer: fetches words, resolves JMP/BR itself,
// hands ordinary instructions to execute, and commands the free-running counter each cycle.
module fetch_sequencer (
    input  logic              Clock,
    input  logic              Reset,
    fetch_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_OPFETCH,
        S_OPWAIT
    } state_t;

    localparam logic [3:0] OP_JMP = 4'hE;
    localparam logic [3:0] OP_BR  = 4'hF;

    state_t            state_q, state_d;
    logic [15:0]       ir_q, ir_d;
    logic [15:0]       ipc_q, ipc_d;

    logic              br_taken;
    logic [15:0]       load_value;
    logic              load_enable;
    logic signed [8:0] offset;
    logic              offset_enable;
    logic              instr_read;
    logic              instr_valid;

    // Flags are {N, Z}; codes 101..111 never branch.
    always_comb begin
        case (ir_q[11:9])
            3'b000:  br_taken = 1'b1;
            3'b001:  br_taken = bus.Flags[0];
            3'b010:  br_taken = ~bus.Flags[0];
            3'b011:  br_taken = bus.Flags[1];
            3'b100:  br_taken = ~bus.Flags[1];
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_FETCH;
            ir_q    <= 16'h0000;
            ipc_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ipc_q   <= ipc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        ipc_d         = ipc_q;
        load_value    = 16'h0000;
        load_enable   = 1'b0;
        offset        = 9'sd0;
        offset_enable = 1'b1;
        instr_read    = 1'b0;
        instr_valid   = 1'b0;

        case (state_q)
            S_FETCH: begin
                instr_read = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (bus.InstrReady) begin
                    ir_d    = bus.InstrData;
                    ipc_d   = bus.CounterValue;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // The counter still holds IPC here, so a taken branch offset lands on IPC+offset.
                if (ir_q[15:12] == OP_BR) begin
                    offset_enable = br_taken;
                    offset        = br_taken ? $signed(ir_q[8:0]) : 9'sd0;
                    state_d       = S_FETCH;
                end else if (ir_q[15:12] == OP_JMP) begin
                    offset_enable = 1'b0;
                    state_d       = S_OPFETCH;
                end else begin
                    instr_valid = 1'b1;
                    if (bus.InstrAccept) begin
                        offset_enable = 1'b0;
                        state_d       = S_FETCH;
                    end
                end
            end
            S_OPFETCH: begin
                instr_read = 1'b1;
                state_d    = S_OPWAIT;
            end
            S_OPWAIT: begin
                if (bus.InstrReady) begin
                    load_enable   = 1'b1;
                    offset_enable = 1'b0;
                    load_value    = bus.InstrData;
                    state_d       = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        if (Reset) begin
            load_value    = 16'h0000;
            load_enable   = 1'b0;
            offset        = 9'sd0;
            offset_enable = 1'b1;
            instr_read    = 1'b0;
            instr_valid   = 1'b0;
        end
    end

    assign bus.LoadValue    = load_value;
    assign bus.LoadEnable   = load_enable;
    assign bus.Offset       = offset;
    assign bus.OffsetEnable = offset_enable;
    assign bus.InstrAddress = bus.CounterValue;
    assign bus.InstrRead    = instr_read;
    assign bus.InstrOut     = ir_q;
    assign bus.InstrPC      = ipc_q;
    assign bus.InstrValid   = instr_valid;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: models the counter and program memory, and predicts
// fetch addresses, issued instructions and jump loads from the instruction-set rules.
module tb_fetch_sequencer;
    logic Clock = 1'b0;
    logic Reset = 1'b1;

    fetch_sequencer_if bus ();

    fetch_sequencer dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.master)
    );

    always #5 Clock = ~Clock;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] mem [0:65535];

    int lat_min = 1, lat_max = 1, accept_pct = 100, spurious_pct = 0, flags_force = -1;
    bit reset_next = 1'b1, keep_stale = 1'b0;

    bit          rd_pend = 1'b0, rd_stale = 1'b0;
    logic [15:0] rd_addr = 16'h0;
    int          rd_cnt = 0;
    logic [15:0] cnt_next = 16'h0;
    logic [1:0]  flags_ref = 2'b00;

    logic [15:0] pc_ref = 16'h0;
    bit          operand_phase = 1'b0, issue_pend = 1'b0, load_pend = 1'b0;
    logic [15:0] issue_word = 16'h0, issue_pc = 16'h0, load_val = 16'h0;
    int          cyc = 0, idle = 0, issues_total = 0;

    int          read_cyc_log[$];
    logic [15:0] read_addr_log[$];
    int          issue_cyc_log[$];
    logic [15:0] issue_pc_log[$];
    int          load_cyc_log[$];

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit br_cond(input logic [2:0] c, input logic [1:0] f);
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return f[0];
            3'd2:    return !f[0];
            3'd3:    return f[1];
            3'd4:    return !f[1];
            default: return 1'b0;
        endcase
    endfunction

    // Architectural view: each fetch of an instruction word decides where the next fetch goes.
    task automatic observe();
        logic [15:0] w;
        int off;
        if (Reset) begin
            check_output("rst_read", 32'(bus.InstrRead), 32'd0);
            check_output("rst_valid", 32'(bus.InstrValid), 32'd0);
            check_output("rst_load", 32'(bus.LoadEnable), 32'd0);
            check_output("rst_hold", {15'd0, bus.OffsetEnable, 7'd0, bus.Offset}, 32'h0001_0000);
            cnt_next = 16'h0;
            pc_ref = 16'h0;
            operand_phase = 1'b0;
            issue_pend = 1'b0;
            load_pend = 1'b0;
            idle = 0;
            read_cyc_log.delete(); read_addr_log.delete();
            issue_cyc_log.delete(); issue_pc_log.delete(); load_cyc_log.delete();
            if (keep_stale) rd_stale = rd_pend;
            else rd_pend = 1'b0;
            cyc = 0;
            return;
        end
        check_output("cmd_exclusive", 32'(bus.LoadEnable & bus.OffsetEnable), 32'd0);
        if (bus.InstrRead) begin
            check_output("rd_addr", 32'(bus.InstrAddress), 32'(pc_ref));
            check_output("rd_early", 32'(issue_pend | load_pend), 32'd0);
            read_cyc_log.push_back(cyc);
            read_addr_log.push_back(bus.InstrAddress);
            rd_pend = 1'b1;
            rd_stale = 1'b0;
            rd_addr = bus.InstrAddress;
            rd_cnt = $urandom_range(lat_max, lat_min);
            idle = 0;
            if (operand_phase) begin
                load_pend = 1'b1;
                load_val = mem[pc_ref];
                pc_ref = load_val;
                operand_phase = 1'b0;
            end else begin
                flags_ref = (flags_force >= 0) ? 2'(flags_force) : 2'($urandom_range(3));
                w = mem[pc_ref];
                if (w[15:12] == 4'hE) begin
                    operand_phase = 1'b1;
                    pc_ref = pc_ref + 16'd1;
                end else if (w[15:12] == 4'hF) begin
                    off = w[8] ? int'(w[8:0]) - 512 : int'(w[8:0]);
                    if (!br_cond(w[11:9], flags_ref)) off = 1;
                    pc_ref = 16'((int'(pc_ref) + off) & 32'hFFFF);
                end else begin
                    issue_pend = 1'b1;
                    issue_word = w;
                    issue_pc = pc_ref;
                    pc_ref = pc_ref + 16'd1;
                end
            end
        end
        if (bus.InstrValid) begin
            check_output("valid_expected", 32'(issue_pend), 32'd1);
            if (issue_pend) begin
                check_output("out_word", 32'(bus.InstrOut), 32'(issue_word));
                check_output("out_pc", 32'(bus.InstrPC), 32'(issue_pc));
                if (bus.InstrAccept) begin
                    issue_pend = 1'b0;
                    issue_cyc_log.push_back(cyc);
                    issue_pc_log.push_back(bus.InstrPC);
                    issues_total++;
                    idle = 0;
                end
            end
        end
        if (bus.LoadEnable) begin
            check_output("load_expected", 32'(load_pend), 32'd1);
            if (load_pend) begin
                check_output("load_value", 32'(bus.LoadValue), 32'(load_val));
                load_pend = 1'b0;
                load_cyc_log.push_back(cyc);
            end
        end
        idle++;
        check_output("watchdog", 32'(idle > 40), 32'd0);
        if (idle > 40) idle = 0;
        if (bus.LoadEnable) cnt_next = bus.LoadValue;
        else if (bus.OffsetEnable) cnt_next = bus.CounterValue + 16'(bus.Offset);
        else cnt_next = bus.CounterValue + 16'd1;
        cyc++;
    endtask

    task automatic apply_stimulus();
        Reset = reset_next;
        bus.CounterValue = cnt_next;
        if (rd_pend) begin
            rd_cnt--;
            if (rd_cnt <= 0) begin
                bus.InstrReady = 1'b1;
                bus.InstrData = rd_stale ? 16'hDEAD : mem[rd_addr];
                rd_pend = 1'b0;
            end else begin
                bus.InstrReady = 1'b0;
                bus.InstrData = 16'($urandom);
            end
        end else begin
            bus.InstrReady = ($urandom_range(99) < spurious_pct);
            bus.InstrData = 16'($urandom);
        end
        bus.InstrAccept = ($urandom_range(99) < accept_pct);
        bus.Flags = flags_ref;
    endtask

    task automatic step();
        @(negedge Clock);
        observe();
        @(posedge Clock);
        #1;
        apply_stimulus();
    endtask

    task automatic do_reset(input int n);
        reset_next = 1'b1;
        repeat (n) step();
        reset_next = 1'b0;
        step();
    endtask

    // Runs a JMP at 0 to target and returns with the first few reads logged.
    task automatic jump_then(input logic [15:0] target, input logic [15:0] word, input int n);
        mem[16'h0000] = 16'hE000;
        mem[16'h0001] = target;
        mem[target] = word;
        do_reset(2);
        repeat (n) step();
    endtask

    initial begin
        bus.CounterValue = 16'h0;
        bus.InstrReady = 1'b0;
        bus.InstrData = 16'h0;
        bus.Flags = 2'b00;
        bus.InstrAccept = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;

        $display("[TB] ordinary words with immediate accept");
        mem[0] = 16'h1234;
        mem[1] = 16'h5678;
        do_reset(2);
        repeat (7) step();
        check_output("t1_issue_count", 32'(issue_cyc_log.size() >= 2), 32'd1);
        check_output("t1_first_cycle", 32'(issue_cyc_log[0]), 32'd2);
        check_output("t1_second_cycle", 32'(issue_cyc_log[1]), 32'd5);
        check_output("t1_second_pc", 32'(issue_pc_log[1]), 32'h0001);

        $display("[TB] four-cycle accept stall");
        accept_pct = 0;
        do_reset(2);
        repeat (5) step();
        accept_pct = 100;
        repeat (4) step();
        check_output("t2_issue_cycle", 32'(issue_cyc_log[0]), 32'd6);
        check_output("t2_next_read_cycle", 32'(read_cyc_log[1]), 32'd7);

        $display("[TB] jump then branch always -2");
        mem[16'h000E] = 16'h1111;
        jump_then(16'h0010, 16'hF1FE, 14);
        check_output("t3_jmp_operand_cycle", 32'(read_cyc_log[1]), 32'd3);
        check_output("t3_load_cycle", 32'(load_cyc_log[0]), 32'd4);
        check_output("t3_jmp_target_cycle", 32'(read_cyc_log[2]), 32'd5);
        check_output("t3_br_target", 32'(read_addr_log[3]), 32'h000E);
        check_output("t3_br_cycle", 32'(read_cyc_log[3]), 32'd8);
        check_output("t3_first_issue_pc", 32'(issue_pc_log[0]), 32'h000E);

        $display("[TB] conditional branch on Z");
        flags_force = 0;
        jump_then(16'h0010, 16'hF204, 10);
        check_output("t3_z0_not_taken", 32'(read_addr_log[3]), 32'h0011);
        flags_force = 1;
        jump_then(16'h0010, 16'hF204, 10);
        check_output("t3_z1_taken", 32'(read_addr_log[3]), 32'h0014);
        flags_force = -1;

        $display("[TB] address wrap");
        jump_then(16'hFFFF, 16'h2222, 12);
        check_output("t4_wrap_increment", 32'(read_addr_log[3]), 32'h0000);
        jump_then(16'hFFFE, 16'hF005, 10);
        check_output("t4_wrap_branch", 32'(read_addr_log[3]), 32'h0003);

        $display("[TB] reset during wait with late ready");
        mem[0] = 16'h1234;
        mem[1] = 16'h0000;
        lat_min = 2;
        lat_max = 2;
        keep_stale = 1'b1;
        do_reset(2);
        reset_next = 1'b1;
        step();
        reset_next = 1'b0;
        lat_min = 1;
        lat_max = 1;
        step();
        keep_stale = 1'b0;
        repeat (6) step();
        check_output("t5_restart_addr", 32'(read_addr_log[0]), 32'h0000);
        check_output("t5_restart_cycle", 32'(read_cyc_log[0]), 32'd0);
        check_output("t5_issue_cycle", 32'(issue_cyc_log[0]), 32'd2);

        $display("[TB] randomized program");
        for (int i = 0; i < 65536; i++) begin
            int r;
            r = $urandom_range(99);
            if (r < 70) mem[i] = {4'($urandom_range(13)), 12'($urandom)};
            else if (r < 85) mem[i] = {4'hF, 12'($urandom)};
            else mem[i] = {4'hE, 12'($urandom)};
        end
        lat_min = 1;
        lat_max = 3;
        accept_pct = 70;
        spurious_pct = 10;
        issues_total = 0;
        do_reset(2);
        for (int i = 0; i < 4000; i++) begin
            reset_next = ($urandom_range(299) == 0);
            step();
        end
        check_output("rand_progress", 32'(issues_total > 100), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
